// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch sequencer: reset/trap vectors, state encodings, trap causes.
// Optional feature macro used by this slice: FETCH_PERF_CNT_EN (adds retire/stall counters).
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_0180;

  localparam logic [2:0] FC_BOOT    = 3'd0;
  localparam logic [2:0] FC_REQ     = 3'd1;
  localparam logic [2:0] FC_WAIT    = 3'd2;
  localparam logic [2:0] FC_DELIVER = 3'd3;
  localparam logic [2:0] FC_HALT    = 3'd4;

  localparam logic [1:0] FC_CAUSE_BUSERR = 2'd1;
  localparam logic [1:0] FC_CAUSE_ALIGN  = 2'd2;
  localparam logic [1:0] FC_CAUSE_IRQ    = 2'd3;

  function automatic logic misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port plus decode/retire handshake between fetch_ctrl and its neighbours.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic        imem_rerr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] npc;
  logic        halt;
  logic        irq;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rerr, imem_rdata, inst_ready, npc, halt, irq
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rerr, imem_rdata, inst_ready, npc, halt, irq
  );
endinterface

// File: rtl/fetch_perf_cnt.sv
// Free-running retire and stall counters; both wrap naturally at 2^32.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rstn,
  input  logic        retire,
  input  logic        stall,
  output logic [31:0] retire_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (retire) retire_cnt <= retire_cnt + 32'd1;
      if (stall)  stall_cnt  <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Multi-cycle fetch sequencer: owns the PC, fetches over req/gnt/rvalid, presents to decode, takes traps.
// Define FETCH_PERF_CNT_EN to add retire_cnt/stall_cnt outputs.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  fetch_ctrl_if.master bus,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] epc,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] retire_cnt,
  output logic [31:0] stall_cnt
`endif
);

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;

  // Handshake outputs come straight from registered state, never from inputs.
  assign bus.imem_req   = (state == FC_REQ);
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = (state == FC_DELIVER);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= FC_BOOT;
      pc         <= RESET_PC;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      trap       <= 1'b0;
      trap_cause <= '0;
      epc        <= '0;
      halted     <= 1'b0;
    end else begin
      trap <= 1'b0;
      case (state)
        FC_BOOT: state <= FC_REQ;
        FC_REQ:  if (bus.imem_gnt) state <= FC_WAIT;
        FC_WAIT: begin
          if (bus.imem_rvalid) begin
            if (bus.imem_rerr) begin
              trap       <= 1'b1;
              trap_cause <= FC_CAUSE_BUSERR;
              epc        <= pc;
              pc         <= EXC_VEC;
              state      <= FC_REQ;
            end else begin
              inst_q    <= bus.imem_rdata;
              inst_pc_q <= pc;
              state     <= FC_DELIVER;
            end
          end
        end
        FC_DELIVER: begin
          if (bus.inst_ready) begin
            // halt beats any trap; the PC is left pointing at the halting instruction's fetch
            if (bus.halt) begin
              halted <= 1'b1;
              state  <= FC_HALT;
            end else begin
              state <= FC_REQ;
              if (misaligned(bus.npc)) begin
                trap       <= 1'b1;
                trap_cause <= FC_CAUSE_ALIGN;
                epc        <= bus.npc;
                pc         <= EXC_VEC;
              end else if (bus.irq) begin
                trap       <= 1'b1;
                trap_cause <= FC_CAUSE_IRQ;
                epc        <= bus.npc;
                pc         <= EXC_VEC;
              end else begin
                pc <= bus.npc;
              end
            end
          end
        end
        FC_HALT: state <= FC_HALT;
        default: state <= FC_BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic retire, stall;
  assign retire = (state == FC_DELIVER) && bus.inst_ready;
  assign stall  = ((state == FC_REQ)     && !bus.imem_gnt)    ||
                  ((state == FC_WAIT)    && !bus.imem_rvalid) ||
                  ((state == FC_DELIVER) && !bus.inst_ready);

  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rstn      (rstn),
    .retire    (retire),
    .stall     (stall),
    .retire_cnt(retire_cnt),
    .stall_cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: table of fetch transactions plus reset corner sequences.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if bus();
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] epc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retire_cnt, stall_cnt;
`endif

  fetch_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .trap      (trap),
    .trap_cause(trap_cause),
    .epc       (epc),
    .halted    (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retire_cnt(retire_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          gd, rd, yd;
    logic [31:0] rdata;
    logic        rerr;
    logic [31:0] npc;
    logic        halt, irq;
    logic [31:0] nx_addr;
    logic        nx_trap;
    logic [1:0]  nx_cause;
    logic [31:0] nx_epc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];
  vec_t tv[8];

  task automatic idle_inputs();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rerr   = 1'b0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 1'b0;
    bus.npc         = '0;
    bus.halt        = 1'b0;
    bus.irq         = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic t, input logic [1:0] c, input logic [31:0] e);
    exp_t x;
    x.addr = a; x.trap = t; x.cause = c; x.epc = e;
    sb.push_back(x);
  endtask

  // Waits (bounded) for a fetch request, then checks it against the oldest scoreboard entry.
  task automatic wait_req(input bit immediate, output exp_t e);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, bus.imem_req}, 32'd1);
    if (immediate) chk("req_latency", n, 32'd0);
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_underflow: got empty queue want entry");
      e.addr = 'x; e.trap = 1'b0; e.cause = '0; e.epc = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("fetch_addr", bus.imem_addr, e.addr);
    chk("trap_pulse", {31'd0, trap}, {31'd0, e.trap});
    if (e.trap) begin
      chk("trap_cause", {30'd0, trap_cause}, {30'd0, e.cause});
      chk("epc", epc, e.epc);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit immediate);
    exp_t e;
    bit ok;
    wait_req(immediate, e);
    ok = 1'b1;
    for (int i = 0; i < v.gd; i++) begin
      @(negedge clk);
      if (!bus.imem_req || bus.imem_addr !== e.addr || trap) ok = 1'b0;
    end
    if (v.gd > 0) chk("req_held", {31'd0, ok}, 32'd1);
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    ok = 1'b1;
    if (bus.imem_req || bus.inst_valid) ok = 1'b0;
    for (int i = 0; i < v.rd; i++) begin
      @(negedge clk);
      if (bus.imem_req || bus.inst_valid) ok = 1'b0;
    end
    chk("wait_quiet", {31'd0, ok}, 32'd1);
    bus.imem_rvalid = 1'b1;
    bus.imem_rerr   = v.rerr;
    bus.imem_rdata  = v.rdata;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    bus.imem_rerr   = 1'b0;
    bus.imem_rdata  = ~v.rdata;
    if (v.rerr) begin
      chk("no_inst_on_err", {31'd0, bus.inst_valid}, 32'd0);
      push_exp(v.nx_addr, v.nx_trap, v.nx_cause, v.nx_epc);
      return;
    end
    chk("inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("inst", bus.inst, v.rdata);
    chk("inst_pc", bus.inst_pc, e.addr);
    ok = 1'b1;
    for (int i = 0; i < v.yd; i++) begin
      @(negedge clk);
      if (!bus.inst_valid || bus.inst !== v.rdata || bus.inst_pc !== e.addr) ok = 1'b0;
    end
    if (v.yd > 0) chk("inst_stable", {31'd0, ok}, 32'd1);
    bus.inst_ready = 1'b1;
    bus.npc        = v.npc;
    bus.halt       = v.halt;
    bus.irq        = v.irq;
    @(negedge clk);
    idle_inputs();
    bus.npc = $urandom;
    if (v.halt) begin
      chk("halted", {31'd0, halted}, 32'd1);
      chk("halt_no_trap", {31'd0, trap}, 32'd0);
      ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
        if (bus.imem_req || bus.inst_valid || trap || !halted) ok = 1'b0;
        bus.inst_ready = i[0];
        bus.imem_gnt   = i[1];
        @(negedge clk);
      end
      idle_inputs();
      chk("halt_absorb", {31'd0, ok}, 32'd1);
    end else begin
      chk("not_halted", {31'd0, halted}, 32'd0);
      push_exp(v.nx_addr, v.nx_trap, v.nx_cause, v.nx_epc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, bus.imem_req},   32'd0);
    chk({tag, "_addr"},  bus.imem_addr,           RESET_PC);
    chk({tag, "_ival"},  {31'd0, bus.inst_valid}, 32'd0);
    chk({tag, "_inst"},  bus.inst,                32'd0);
    chk({tag, "_ipc"},   bus.inst_pc,             32'd0);
    chk({tag, "_trap"},  {31'd0, trap},           32'd0);
    chk({tag, "_cause"}, {30'd0, trap_cause},     32'd0);
    chk({tag, "_epc"},   epc,                     32'd0);
    chk({tag, "_halt"},  {31'd0, halted},         32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    vec_t v;
    idle_inputs();
    //        gd rd yd rdata          rerr npc           halt irq  nx_addr       trap cause epc
    tv[0] = '{0, 0, 0, 32'h2008_0005, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 2'd0, 32'h0};
    tv[1] = '{4, 3, 2, 32'h1111_2222, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 2'd0, 32'h0};
    tv[2] = '{1, 0, 1, 32'h3333_4444, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 2'd0, 32'h0};
    tv[3] = '{0, 1, 0, 32'h5555_6666, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0180, 1'b1, 2'd1, 32'h10};
    tv[4] = '{2, 0, 0, 32'h7777_8888, 1'b0, 32'h0000_0022, 1'b0, 1'b0, 32'h0000_0180, 1'b1, 2'd2, 32'h22};
    tv[5] = '{0, 2, 1, 32'h9999_aaaa, 1'b0, 32'h0000_0008, 1'b0, 1'b1, 32'h0000_0180, 1'b1, 2'd3, 32'h08};
    tv[6] = '{1, 1, 0, 32'hbbbb_cccc, 1'b0, 32'h0000_0184, 1'b0, 1'b0, 32'h0000_0184, 1'b0, 2'd0, 32'h0};
    tv[7] = '{0, 0, 3, 32'hdddd_eeee, 1'b0, 32'h0000_0022, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 2'd0, 32'h0};

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rstn = 1'b1;
    push_exp(RESET_PC, 1'b0, 2'd0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      run_vec(tv[i], i > 0);
`ifdef FETCH_PERF_CNT_EN
      if (i == 1) begin
        chk("retire_cnt", retire_cnt, 32'd2);
        chk("stall_cnt",  stall_cnt,  32'd9);
      end
`endif
    end
`ifdef FETCH_PERF_CNT_EN
    chk("retire_cnt_end", retire_cnt, 32'd7);
`endif

    // Leave halt by reset.
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_vals("halt_rst");
    rstn = 1'b1;
    push_exp(RESET_PC, 1'b0, 2'd0, 32'h0);
    v = '{0, 0, 0, 32'h0bad_c0de, 1'b0, 32'h0000_0022, 1'b0, 1'b0, 32'h0000_0180, 1'b1, 2'd2, 32'h22};
    run_vec(v, 1'b0);

    // Reset in the middle of S_WAIT; the late response must be dropped.
    wait_req(1'b1, e);
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    #2 rstn = 1'b0;
    #1 chk_reset_vals("midwait");
    @(negedge clk);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hfeed_face;
    rstn = 1'b1;
    @(negedge clk);
    idle_inputs();
    chk("restart_req",  {31'd0, bus.imem_req},   32'd1);
    chk("restart_ival", {31'd0, bus.inst_valid}, 32'd0);
    chk("restart_inst", bus.inst,                32'd0);
    push_exp(RESET_PC, 1'b0, 2'd0, 32'h0);
    v = '{1, 1, 1, 32'h1357_9bdf, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 2'd0, 32'h0};
    run_vec(v, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
